// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259A host bus master.
package pic_pkg;

  typedef enum logic [2:0] {BS_IDLE, BS_SETUP, BS_STROBE, BS_HOLD, BS_GAP} bus_state_t;
  typedef enum logic [1:0] {ICW1, ICW2, ICW3, ICW4} icw_step_t;
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_WRITE, S_READ} seq_state_t;

  localparam int ICW1_IC4  = 0;  // ICW4 needed
  localparam int ICW1_SNGL = 1;  // single PIC, no ICW3
  localparam int ICW1_ID   = 4;  // marks the word as ICW1 on the bus

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Step following s; ICW3/ICW4 are skipped according to ICW1.
  function automatic icw_step_t icw_next(input icw_step_t s, input logic [7:0] w1);
    case (s)
      ICW1:    return ICW2;
      ICW2:    return w1[ICW1_SNGL] ? ICW4 : ICW3;
      default: return ICW4;
    endcase
  endfunction

  // True when s is the final ICW of the sequence described by ICW1.
  function automatic logic icw_is_last(input icw_step_t s, input logic [7:0] w1);
    case (s)
      ICW1:    return 1'b0;
      ICW2:    return w1[ICW1_SNGL] && !w1[ICW1_IC4];
      ICW3:    return !w1[ICW1_IC4];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/pic_bus_cycle_gen.sv
// SETUP/STROBE/HOLD/GAP timing engine for one PIC bus cycle.
// Optional read strobe under PIC_HOST_READBACK_EN.
module pic_bus_cycle_gen
  import pic_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cycle_start,
  input  logic       cyc_rd,
  input  logic       cyc_a0,
  input  logic [7:0] cyc_data,
  output logic       chip_select,
  output logic       write_enable,
  output logic       read_enable,
  output logic       A0,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  output logic       ready,
  output logic       strobe_last,
  output logic       cycle_done
);

  localparam int CW = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  bus_state_t    state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          a0_q, rd_q;
  logic [7:0]    data_q;

  // A new cycle may only begin from IDLE or the single GAP cycle.
  assign ready        = (state_q == BS_IDLE) || (state_q == BS_GAP);
  assign A0           = a0_q;
  assign data_bus_out = data_q;

  // State, phase counter and latched address/data for the cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= BS_IDLE;
      cnt_q   <= '0;
      a0_q    <= 1'b0;
      rd_q    <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      if (cycle_start && ready) begin
        a0_q   <= cyc_a0;
        rd_q   <= cyc_rd;
        data_q <= cyc_data;
      end
    end
  end

  // Phase sequencing; each phase counts to its configured length.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      BS_IDLE, BS_GAP: begin
        cnt_n   = '0;
        state_n = cycle_start ? BS_SETUP : BS_IDLE;
      end
      BS_SETUP:
        if (cnt_q == SETUP_LAST) begin state_n = BS_STROBE; cnt_n = '0; end
        else cnt_n = cnt_q + 1'b1;
      BS_STROBE:
        if (cnt_q == PULSE_LAST) begin state_n = BS_HOLD; cnt_n = '0; end
        else cnt_n = cnt_q + 1'b1;
      BS_HOLD:
        if (cnt_q == HOLD_LAST) begin state_n = BS_GAP; cnt_n = '0; end
        else cnt_n = cnt_q + 1'b1;
      default: begin state_n = BS_IDLE; cnt_n = '0; end
    endcase
  end

  // Bus pins decoded from phase; the strobe rises inside the select window.
  always_comb begin
    chip_select  = 1'b1;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    data_bus_oe  = 1'b0;
    strobe_last  = 1'b0;
    cycle_done   = 1'b0;
    case (state_q)
      BS_SETUP: begin
        chip_select = 1'b0;
        data_bus_oe = !rd_q;
      end
      BS_STROBE: begin
        chip_select = 1'b0;
        data_bus_oe = !rd_q;
        strobe_last = (cnt_q == PULSE_LAST);
        if (!rd_q) write_enable = 1'b0;
`ifdef PIC_HOST_READBACK_EN
        else read_enable = 1'b0;
`endif
      end
      BS_HOLD: begin
        chip_select = 1'b0;
        data_bus_oe = !rd_q;
        cycle_done  = (cnt_q == HOLD_LAST);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pic_host_bus_master.sv
// Host bus initiator for the 8259A PIC: arbitration, ICW1-ICW4 sequencing
// and single writes. Define PIC_HOST_READBACK_EN to enable read cycles.
module pic_host_bus_master
  import pic_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  input  logic       wr_req,
  input  logic       wr_a0,
  input  logic [7:0] wr_data,
  input  logic       rd_req,
  input  logic       rd_a0,
  input  logic [7:0] data_bus_in,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  output logic       chip_select,
  output logic       write_enable,
  output logic       read_enable,
  output logic       A0,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data,
  output logic       rd_valid
);

  seq_state_t state_q, state_n;
  icw_step_t  step_q, step_n;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
  logic       cycle_start, cyc_a0, cyc_rd, finish, rd_go;
  logic [7:0] cyc_data;
  logic       eng_ready, eng_strobe_last, eng_cycle_done;

`ifdef PIC_HOST_READBACK_EN
  assign rd_go = rd_req;
`else
  assign rd_go = 1'b0;
  logic unused_rd;
  assign unused_rd = &{1'b0, rd_req, rd_a0, data_bus_in, eng_strobe_last};
`endif

  assign busy = (state_q != S_IDLE);

  pic_bus_cycle_gen #(
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC)
  ) u_cyc (
    .clk(clk), .reset(reset),
    .cycle_start(cycle_start), .cyc_rd(cyc_rd), .cyc_a0(cyc_a0), .cyc_data(cyc_data),
    .chip_select(chip_select), .write_enable(write_enable), .read_enable(read_enable),
    .A0(A0), .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
    .ready(eng_ready), .strobe_last(eng_strobe_last), .cycle_done(eng_cycle_done)
  );

  // Sequencer state; done is registered so it lands in the GAP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= ICW1;
      done    <= 1'b0;
    end else begin
      state_q <= state_n;
      step_q  <= step_n;
      done    <= finish;
    end
  end

  // ICW words are captured once, when the init request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      icw1_q <= 8'h00; icw2_q <= 8'h00; icw3_q <= 8'h00; icw4_q <= 8'h00;
    end else if (state_q == S_IDLE && init_start) begin
      icw1_q <= icw1; icw2_q <= icw2; icw3_q <= icw3; icw4_q <= icw4;
    end
  end

  // Arbitration in IDLE (init > write > read) and ICW step advance.
  always_comb begin
    state_n = state_q;
    step_n  = step_q;
    case (state_q)
      S_IDLE:
        if (init_start)  begin state_n = S_INIT; step_n = ICW1; end
        else if (wr_req) state_n = S_WRITE;
        else if (rd_go)  state_n = S_READ;
      S_INIT:
        if (eng_cycle_done) begin
          if (icw_is_last(step_q, icw1_q)) state_n = S_IDLE;
          else step_n = icw_next(step_q, icw1_q);
        end
      default:
        if (eng_cycle_done) state_n = S_IDLE;
    endcase
  end

  // Cycle requests to the engine and the completion strobe.
  always_comb begin
    cycle_start = 1'b0;
    cyc_a0      = 1'b0;
    cyc_rd      = 1'b0;
    cyc_data    = 8'h00;
    finish      = 1'b0;
    case (state_q)
      S_IDLE:
        if (init_start) begin
          cycle_start = 1'b1;
          cyc_data    = icw1 | (8'h01 << ICW1_ID);
        end else if (wr_req) begin
          cycle_start = 1'b1;
          cyc_a0      = wr_a0;
          cyc_data    = wr_data;
        end else if (rd_go) begin
          cycle_start = 1'b1;
          cyc_rd      = 1'b1;
          cyc_a0      = rd_a0;
        end
      S_INIT: begin
        // The engine is only in GAP here when another ICW is pending.
        cycle_start = eng_ready;
        cyc_a0      = 1'b1;
        case (step_q)
          ICW2:    cyc_data = icw2_q;
          ICW3:    cyc_data = icw3_q;
          ICW4:    cyc_data = icw4_q;
          default: cyc_data = icw1_q | (8'h01 << ICW1_ID);
        endcase
        finish = eng_cycle_done && icw_is_last(step_q, icw1_q);
      end
      default: finish = eng_cycle_done;
    endcase
  end

`ifdef PIC_HOST_READBACK_EN
  // Capture the bus on the last strobe cycle; flag it in the GAP cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      if (state_q == S_READ && eng_strobe_last) rd_data <= data_bus_in;
      rd_valid <= finish && (state_q == S_READ);
    end
  end
`else
  assign rd_data  = 8'h00;
  assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_pic_host_bus_master.sv
// Scoreboard bench: expected (A0,data) writes are queued when stimulus is
// driven and popped by a monitor at each write_enable rising edge.
module tb_pic_host_bus_master;

  logic       clk = 1'b0, reset = 1'b1;
  logic       init_start = 1'b0, wr_req = 1'b0, wr_a0 = 1'b0, rd_req = 1'b0, rd_a0 = 1'b0;
  logic [7:0] icw1 = 8'h00, icw2 = 8'h00, icw3 = 8'h00, icw4 = 8'h00;
  logic [7:0] wr_data = 8'h00, data_bus_in = 8'h00;
  logic [7:0] data_bus_out, rd_data;
  logic       data_bus_oe, chip_select, write_enable, read_enable, A0, busy, done, rd_valid;

  int errors = 0, checks = 0;
  logic [8:0] exp_q[$];
  int  n_writes = 0, done_cnt = 0;
  bit  mon_en = 1'b0;

  pic_host_bus_master dut (
    .clk(clk), .reset(reset), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .wr_req(wr_req), .wr_a0(wr_a0), .wr_data(wr_data),
    .rd_req(rd_req), .rd_a0(rd_a0), .data_bus_in(data_bus_in),
    .data_bus_out(data_bus_out), .data_bus_oe(data_bus_oe),
    .chip_select(chip_select), .write_enable(write_enable), .read_enable(read_enable),
    .A0(A0), .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Monitor: write scoreboard, select-window length, done pulse count.
  initial begin
    logic       we_prev, cs_prev;
    logic [8:0] d_strobe, e;
    int         cs_run;
    we_prev = 1'b1; cs_prev = 1'b1; cs_run = 0; d_strobe = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (!write_enable) d_strobe = {A0, data_bus_out};
        if (write_enable && !we_prev) begin
          checks++;
          n_writes++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_write: got A0/data=%03h, required no write", {A0, data_bus_out});
          end else begin
            e = exp_q.pop_front();
            if ({chip_select, A0, data_bus_out} !== {1'b0, e} || d_strobe !== e) begin
              errors++;
              $display("FAIL write_data: got cs=%b A0/data=%03h strobe-time=%03h, required cs=0 %03h",
                       chip_select, {A0, data_bus_out}, d_strobe, e);
            end
          end
        end
        if (done) done_cnt++;
        if (chip_select && !cs_prev) begin
          checks++;
          if (cs_run !== 4) begin
            errors++;
            $display("FAIL cs_window: got %0d low cycles, required 4", cs_run);
          end
        end
        cs_run = chip_select ? 0 : cs_run + 1;
      end else cs_run = 0;
      we_prev = write_enable;
      cs_prev = chip_select;
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({chip_select, write_enable, read_enable, A0, data_bus_out, data_bus_oe, busy, done, rd_data, rd_valid}
        !== {1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: got cs=%b we=%b re=%b A0=%b d=%02h oe=%b busy=%b done=%b rd=%02h rv=%b, required 1 1 1 0 00 0 0 0 00 0",
               chip_select, write_enable, read_enable, A0, data_bus_out, data_bus_oe, busy, done, rd_data, rd_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_init(input logic [7:0] w1, input logic [7:0] w2, input logic [7:0] w3, input logic [7:0] w4);
    int nw, cyc;
    exp_q.push_back({1'b0, w1 | 8'h10}); nw = 1;
    exp_q.push_back({1'b1, w2}); nw++;
    if (!w1[1]) begin exp_q.push_back({1'b1, w3}); nw++; end
    if (w1[0])  begin exp_q.push_back({1'b1, w4}); nw++; end
    done_cnt = 0;
    icw1 = w1; icw2 = w2; icw3 = w3; icw4 = w4; init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    icw1 = ~w1; icw2 = ~w2; icw3 = ~w3; icw4 = ~w4;  // words must have been latched
    checks++;
    if ({busy, chip_select} !== 2'b10) begin
      errors++;
      $display("FAIL init_accept: got busy=%b cs=%b, required busy=1 cs=0", busy, chip_select);
    end
    cyc = 1;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== 5 * nw) begin
      errors++;
      $display("FAIL init_done_time: got done at cycle %0d, required %0d", cyc, 5 * nw);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done_cnt !== 1 || exp_q.size() !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL init_complete: got done pulses=%0d pending writes=%0d busy=%b, required 1 0 0",
               done_cnt, exp_q.size(), busy);
    end
  endtask

  task automatic test_single_write;
    logic [4:0] tbl[5];
    tbl[0] = 5'b01110; tbl[1] = 5'b00110; tbl[2] = 5'b00110; tbl[3] = 5'b01110; tbl[4] = 5'b11001;
    exp_q.push_back({1'b1, 8'hFB});
    wr_a0 = 1'b1; wr_data = 8'hFB; wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0; wr_data = 8'h00;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({chip_select, write_enable, data_bus_oe, busy, done} !== tbl[i]) begin
        errors++;
        $display("FAIL write_cycle%0d: got cs/we/oe/busy/done=%05b, required %05b",
                 i + 1, {chip_select, write_enable, data_bus_oe, busy, done}, tbl[i]);
      end
      if (i < 4) begin
        checks++;
        if ({A0, data_bus_out} !== 9'h1FB) begin
          errors++;
          $display("FAIL write_addr%0d: got A0/data=%03h, required 1fb", i + 1, {A0, data_bus_out});
        end
      end
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL write_seen: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back;
    int w0, cyc;
    w0 = n_writes; done_cnt = 0;
    exp_q.push_back({1'b0, 8'h13}); exp_q.push_back({1'b1, 8'h48}); exp_q.push_back({1'b1, 8'h03});
    icw1 = 8'h13; icw2 = 8'h48; icw3 = 8'h77; icw4 = 8'h03;
    init_start = 1'b1; wr_req = 1'b1; wr_a0 = 1'b1; wr_data = 8'hAA;
    @(negedge clk);
    init_start = 1'b0; wr_req = 1'b0;
    repeat (6) @(negedge clk);
    wr_req = 1'b1;  // arrives while busy, must be ignored
    @(negedge clk);
    wr_req = 1'b0;
    cyc = 8;
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    repeat (6) @(negedge clk);
    checks++;
    if (n_writes - w0 !== 3 || exp_q.size() !== 0 || done_cnt !== 1) begin
      errors++;
      $display("FAIL collision: got writes=%0d pending=%0d dones=%0d, required 3 0 1",
               n_writes - w0, exp_q.size(), done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int lows;
    mon_en = 1'b0;
    wr_a0 = 1'b0; wr_data = 8'h5C; wr_req = 1'b1;
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_setup: got we=%b, required 0 (in strobe)", write_enable);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({chip_select, write_enable, read_enable, busy, done} !== 5'b11100) begin
      errors++;
      $display("FAIL reset_mid: got cs/we/re/busy/done=%05b, required 11100",
               {chip_select, write_enable, read_enable, busy, done});
    end
    reset = 1'b0;
    lows = 0;
    repeat (6) begin @(negedge clk); if (!chip_select || busy) lows++; end
    checks++;
    if (lows !== 0) begin
      errors++;
      $display("FAIL reset_no_resume: got %0d active cycles, required 0", lows);
    end
    exp_q.delete();
    mon_en = 1'b1;
  endtask

`ifdef PIC_HOST_READBACK_EN
  task automatic test_read;
    logic [4:0] tbl[5];
    tbl[0] = 5'b01010; tbl[1] = 5'b00010; tbl[2] = 5'b00010; tbl[3] = 5'b01010; tbl[4] = 5'b11001;
    data_bus_in = 8'h5A; rd_a0 = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({chip_select, read_enable, data_bus_oe, busy, rd_valid} !== tbl[i] || A0 !== 1'b0) begin
        errors++;
        $display("FAIL read_cycle%0d: got cs/re/oe/busy/rv=%05b A0=%b, required %05b A0=0",
                 i + 1, {chip_select, read_enable, data_bus_oe, busy, rd_valid}, A0, tbl[i]);
      end
      if (i == 4) begin
        checks++;
        if (rd_data !== 8'h5A) begin
          errors++;
          $display("FAIL read_data: got %02h, required 5a", rd_data);
        end
      end
      @(negedge clk);
    end
    data_bus_in = 8'h00;
  endtask
`else
  task automatic test_read;
    rd_a0 = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    repeat (2) begin
      checks++;
      if ({busy, chip_select, read_enable, rd_valid} !== 4'b0110) begin
        errors++;
        $display("FAIL read_ignored: got busy/cs/re/rv=%04b, required 0110",
                 {busy, chip_select, read_enable, rd_valid});
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_init(8'h11, 8'h20, 8'h04, 8'h01);
    test_init(8'h13, 8'h30, 8'h08, 8'h03);
    test_init(8'h02, 8'h40, 8'h0C, 8'h05);
    test_single_write();
    test_back_to_back();
    test_reset_mid();
    test_read();
    test_single_write();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
